// File: rtl/disp_scan_ctrl_pkg.sv
// Shared definitions for the 6-digit multiplexed 7-segment scan controller:
// digit count, glyph codes, scan FSM states, display configuration record.
package disp_scan_ctrl_pkg;

  localparam int NDIG = 6;

  localparam logic [6:0] GLYPH_0    = 7'h3F;
  localparam logic [6:0] GLYPH_1    = 7'h06;
  localparam logic [6:0] GLYPH_2    = 7'h5B;
  localparam logic [6:0] GLYPH_3    = 7'h4F;
  localparam logic [6:0] GLYPH_4    = 7'h66;
  localparam logic [6:0] GLYPH_5    = 7'h6D;
  localparam logic [6:0] GLYPH_6    = 7'h7D;
  localparam logic [6:0] GLYPH_7    = 7'h07;
  localparam logic [6:0] GLYPH_8    = 7'h7F;
  localparam logic [6:0] GLYPH_9    = 7'h6F;
  localparam logic [6:0] GLYPH_DASH = 7'h40;
  localparam logic [6:0] GLYPH_OFF  = 7'h00;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  typedef struct packed {
    logic [23:0] digits;
    logic [5:0]  dp;
    logic [5:0]  blink_mask;
    logic        lz_en;
  } disp_cfg_t;

  localparam disp_cfg_t CFG_RESET = '{digits: 24'h000000, dp: 6'h00, blink_mask: 6'h00, lz_en: 1'b0};

  // Digit n (5..1) is blanked while it and every digit to its left are zero.
  function automatic logic [5:0] lz_mask(input logic [23:0] digits, input logic lz_en);
    logic [5:0] m;
    logic       zero_run;
    m        = 6'b000000;
    zero_run = 1'b1;
    for (int n = NDIG - 1; n >= 1; n--) begin
      zero_run = zero_run & (digits[n*4 +: 4] == 4'h0);
      m[n]     = lz_en & zero_run;
    end
    return m;
  endfunction

endpackage

// File: rtl/disp_scan_ctrl_bcd_to_seg.sv
// Combinational BCD to 7-segment decoder; segments active high, [0]=a .. [6]=g.
// Non-decimal nibbles render as a dash.
module bcd_to_seg
  import disp_scan_ctrl_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Glyph lookup
  always_comb begin
    o_seg = GLYPH_DASH;
    case (i_bcd)
      4'h0:    o_seg = GLYPH_0;
      4'h1:    o_seg = GLYPH_1;
      4'h2:    o_seg = GLYPH_2;
      4'h3:    o_seg = GLYPH_3;
      4'h4:    o_seg = GLYPH_4;
      4'h5:    o_seg = GLYPH_5;
      4'h6:    o_seg = GLYPH_6;
      4'h7:    o_seg = GLYPH_7;
      4'h8:    o_seg = GLYPH_8;
      4'h9:    o_seg = GLYPH_9;
      default: o_seg = GLYPH_DASH;
    endcase
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Six-digit multiplexed 7-segment scan controller with anti-ghost blanking,
// leading-zero suppression, blinking and frame-synchronous display loading.
module disp_scan_ctrl
  import disp_scan_ctrl_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int SCAN_HZ   = 6000,
  parameter int BLANK_CYC = 50,
  parameter int BLINK_HZ  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] i_digits,
  input  logic [5:0]  i_dp,
  input  logic [5:0]  i_blink_mask,
  input  logic        i_lz_en,
  input  logic        i_load,
  output logic [5:0]  o_seg_enb,
  output logic        o_seg_dp,
  output logic [6:0]  o_seg,
  output logic        o_frame_done
);

  localparam int DIV       = CLK_HZ / SCAN_HZ;
  localparam int CNT_W     = $clog2(DIV);
  localparam int BLINK_FRM = SCAN_HZ / (NDIG * 2 * BLINK_HZ);
  localparam int BLK_W     = (BLINK_FRM > 1) ? $clog2(BLINK_FRM) : 1;

  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_FRM - 1);
  localparam logic [2:0]       DIG_LAST   = 3'(NDIG - 1);

  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [2:0]       digit_idx_q, digit_idx_d;
  scan_state_e      state_q, state_d;
  disp_cfg_t        active_q, active_d;
  disp_cfg_t        pend_cfg_q, pend_cfg_d;
  logic             pend_q, pend_d;
  logic             blink_off_q, blink_off_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic [5:0]       seg_enb_q, seg_enb_d;
  logic [6:0]       seg_q, seg_d;
  logic             seg_dp_q, seg_dp_d;
  logic             frame_done_q, frame_done_d;

  logic             slot_end_s;
  logic             frame_end_s;
  disp_cfg_t        new_cfg_s;
  logic [3:0]       nibble_s;
  logic [6:0]       glyph_s;
  logic [5:0]       lz_s;

  assign slot_end_s  = (slot_cnt_q == SLOT_LAST);
  assign frame_end_s = slot_end_s && (digit_idx_q == DIG_LAST);
  assign new_cfg_s   = '{digits: i_digits, dp: i_dp, blink_mask: i_blink_mask, lz_en: i_lz_en};
  assign nibble_s    = active_q.digits[{digit_idx_q, 2'b00} +: 4];
  assign lz_s        = lz_mask(active_q.digits, active_q.lz_en);

  bcd_to_seg u_dec (
    .i_bcd (nibble_s),
    .o_seg (glyph_s)
  );

  // Slot and digit counters
  always_comb begin
    slot_cnt_d  = slot_cnt_q + CNT_W'(1);
    digit_idx_d = digit_idx_q;
    if (slot_end_s) begin
      slot_cnt_d  = {CNT_W{1'b0}};
      digit_idx_d = (digit_idx_q == DIG_LAST) ? 3'd0 : digit_idx_q + 3'd1;
    end else begin
      digit_idx_d = digit_idx_q;
    end
  end

  // Scan FSM: dark gap at the start of each slot, then drive
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: begin
        if (slot_cnt_q == BLANK_LAST) state_d = ST_DRIVE;
        else                          state_d = ST_BLANK;
      end
      ST_DRIVE: begin
        if (slot_end_s) state_d = ST_BLANK;
        else            state_d = ST_DRIVE;
      end
      default: state_d = ST_BLANK;
    endcase
  end

  // Pending/active configuration; a load in the boundary cycle bypasses pending
  always_comb begin
    active_d   = active_q;
    pend_cfg_d = pend_cfg_q;
    pend_d     = pend_q;
    if (frame_end_s) begin
      pend_d = 1'b0;
      if (i_load)      active_d = new_cfg_s;
      else if (pend_q) active_d = pend_cfg_q;
      else             active_d = active_q;
    end else if (i_load) begin
      pend_cfg_d = new_cfg_s;
      pend_d     = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  // Blink phase advances once per BLINK_FRM frames
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;
    if (frame_end_s) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = {BLK_W{1'b0}};
        blink_off_d = ~blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end else begin
      blink_cnt_d = blink_cnt_q;
    end
  end

  // Next output values from the current slot state
  always_comb begin
    seg_enb_d    = 6'b000000;
    seg_d        = GLYPH_OFF;
    seg_dp_d     = 1'b0;
    frame_done_d = frame_end_s;
    if ((state_q == ST_DRIVE) && !(blink_off_q && active_q.blink_mask[digit_idx_q])) begin
      seg_enb_d = 6'b000001 << digit_idx_q;
      seg_d     = lz_s[digit_idx_q] ? GLYPH_OFF : glyph_s;
      seg_dp_d  = active_q.dp[digit_idx_q];
    end else begin
      seg_enb_d = 6'b000000;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q   <= {CNT_W{1'b0}};
      digit_idx_q  <= 3'd0;
      state_q      <= ST_BLANK;
      active_q     <= CFG_RESET;
      pend_cfg_q   <= CFG_RESET;
      pend_q       <= 1'b0;
      blink_off_q  <= 1'b0;
      blink_cnt_q  <= {BLK_W{1'b0}};
      seg_enb_q    <= 6'b000000;
      seg_q        <= GLYPH_OFF;
      seg_dp_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      digit_idx_q  <= digit_idx_d;
      state_q      <= state_d;
      active_q     <= active_d;
      pend_cfg_q   <= pend_cfg_d;
      pend_q       <= pend_d;
      blink_off_q  <= blink_off_d;
      blink_cnt_q  <= blink_cnt_d;
      seg_enb_q    <= seg_enb_d;
      seg_q        <= seg_d;
      seg_dp_q     <= seg_dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_seg_enb    = seg_enb_q;
  assign o_seg        = seg_q;
  assign o_seg_dp     = seg_dp_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl: a position-based display model predicts every
// output cycle; a monitor pops and compares on each falling edge.
module tb_disp_scan_ctrl;

  localparam int CLK_HZ    = 1200;
  localparam int SCAN_HZ   = 60;
  localparam int BLANK_CYC = 4;
  localparam int BLINK_HZ  = 1;
  localparam int DIV       = 20;
  localparam int FRAME     = 6 * DIV;
  localparam int BLINK_FRM = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] i_digits = 24'h0;
  logic [5:0]  i_dp = 6'h0;
  logic [5:0]  i_blink_mask = 6'h0;
  logic        i_lz_en = 1'b0;
  logic        i_load = 1'b0;
  logic [5:0]  o_seg_enb;
  logic        o_seg_dp;
  logic [6:0]  o_seg;
  logic        o_frame_done;

  typedef struct {
    logic [23:0] digits;
    logic [5:0]  dp;
    logic [5:0]  mask;
    logic        lz;
  } cfg_t;

  typedef struct {
    logic [5:0] enb;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } obs_t;

  obs_t       exp_q[$];
  cfg_t       load_for[int];
  int         pos = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [6:0] glyph_tab [16];

  disp_scan_ctrl #(
    .CLK_HZ    (CLK_HZ),
    .SCAN_HZ   (SCAN_HZ),
    .BLANK_CYC (BLANK_CYC),
    .BLINK_HZ  (BLINK_HZ)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_digits     (i_digits),
    .i_dp         (i_dp),
    .i_blink_mask (i_blink_mask),
    .i_lz_en      (i_lz_en),
    .i_load       (i_load),
    .o_seg_enb    (o_seg_enb),
    .o_seg_dp     (o_seg_dp),
    .o_seg        (o_seg),
    .o_frame_done (o_frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s pos=%0d got=%0h expected=%0h", name, pos, act, exp);
    end
  endtask

  // Displayed configuration of frame f: the last load issued during an earlier frame.
  function automatic cfg_t content_of(input int f);
    cfg_t c;
    c = '{digits: 24'h0, dp: 6'h0, mask: 6'h0, lz: 1'b0};
    for (int k = 0; k <= f; k++)
      if (load_for.exists(k)) c = load_for[k];
    return c;
  endfunction

  function automatic obs_t expect_at(input int q);
    obs_t e;
    cfg_t cf;
    int   c, d, g;
    bit   off, allz;
    e = '{enb: 6'h0, seg: 7'h0, dp: 1'b0, fd: 1'b0};
    c = q % DIV;
    d = (q / DIV) % 6;
    g = q / FRAME;
    e.fd = (c == DIV - 1) && (d == 5);
    if (c >= BLANK_CYC) begin
      cf  = content_of(g);
      off = ((g / BLINK_FRM) % 2) == 1;
      if (!(off && cf.mask[d])) begin
        e.enb = 6'(1 << d);
        allz = 1'b1;
        for (int k = d; k < 6; k++)
          if (cf.digits[4*k +: 4] != 4'h0) allz = 1'b0;
        e.seg = (cf.lz && d != 0 && allz) ? 7'h00 : glyph_tab[cf.digits[4*d +: 4]];
        e.dp  = cf.dp[d];
      end
    end
    return e;
  endfunction

  // Model: outputs visible after this edge reflect the position just left
  always @(posedge clk) begin
    if (rst_n) begin
      exp_q.push_back(expect_at(pos));
      pos++;
    end
  end

  // Monitor
  always @(negedge clk) begin
    obs_t e;
    if (rst_n) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("seg_enb", {26'h0, o_seg_enb}, {26'h0, e.enb});
        check("seg", {25'h0, o_seg}, {25'h0, e.seg});
        check("seg_dp", {31'h0, o_seg_dp}, {31'h0, e.dp});
        check("frame_done", {31'h0, o_frame_done}, {31'h0, e.fd});
      end
    end
  end

  task automatic scramble_inputs();
    i_digits     = 24'($urandom);
    i_dp         = 6'($urandom);
    i_blink_mask = 6'($urandom);
    i_lz_en      = 1'($urandom);
  endtask

  // Called at a falling edge; the load is sampled at the next rising edge.
  task automatic do_load(input logic [23:0] d, input logic [5:0] p, input logic [5:0] m, input logic lz);
    i_digits     = d;
    i_dp         = p;
    i_blink_mask = m;
    i_lz_en      = lz;
    i_load       = 1'b1;
    load_for[pos / FRAME + 1] = '{digits: d, dp: p, mask: m, lz: lz};
    @(negedge clk);
    i_load = 1'b0;
    scramble_inputs();
  endtask

  task automatic wait_pos_mod(input int target);
    @(negedge clk);
    while ((pos % FRAME) != target) @(negedge clk);
  endtask

  function automatic logic [23:0] rand_bcd();
    logic [23:0] v;
    for (int k = 0; k < 6; k++) v[4*k +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  task automatic check_dark(input string tag);
    check({tag, "_enb"}, {26'h0, o_seg_enb}, 32'h0);
    check({tag, "_seg"}, {25'h0, o_seg}, 32'h0);
    check({tag, "_dp"}, {31'h0, o_seg_dp}, 32'h0);
    check({tag, "_fd"}, {31'h0, o_frame_done}, 32'h0);
  endtask

  initial begin
    bit found;
    glyph_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    scramble_inputs();
    repeat (3) @(negedge clk);
    check_dark("reset");
    #1 rst_n = 1'b1;

    repeat (2 * FRAME) @(negedge clk);
    wait_pos_mod(50);
    do_load(24'h123456, 6'b000100, 6'h00, 1'b0);
    repeat (FRAME) @(negedge clk);
    wait_pos_mod(30);
    do_load(24'h000705, 6'b000010, 6'h00, 1'b1);
    wait_pos_mod(30);
    do_load(rand_bcd(), 6'($urandom), 6'b000011, 1'b0);
    repeat (11 * FRAME) @(negedge clk);

    wait_pos_mod(10);
    do_load(24'h111111, 6'h00, 6'h00, 1'b0);
    repeat (7) @(negedge clk);
    do_load(24'h222222, 6'h3F, 6'h00, 1'b0);
    wait_pos_mod(FRAME - 1);
    do_load(24'h0000A9, 6'h01, 6'h00, 1'b1);
    wait_pos_mod(FRAME - 2);
    do_load(24'h0F0300, 6'h20, 6'h24, 1'b1);
    repeat (FRAME) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(1, 150)) @(negedge clk);
      do_load(24'($urandom), 6'($urandom), 6'($urandom), 1'($urandom));
    end
    wait_pos_mod(60);
    do_load(rand_bcd(), 6'($urandom), 6'h00, 1'($urandom));
    repeat (2 * FRAME) @(negedge clk);

    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (o_seg_enb != 6'h00) found = 1'b1;
    end
    check("drive_seen_before_reset", {31'h0, found}, 32'd1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    load_for.delete();
    pos = 0;
    #1 check_dark("midreset");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2 * FRAME + 5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
